// File: rtl/checker_pkg.sv
// Shared types for the store result checker: FSM states, default widths.
// Imported by fib_term_gen and fib_store_checker.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/fib_term_gen.sv
// Fibonacci-style term generator: term = a; advance does a<=b, b<=a+b.
// Ports: clk, rst (sync, active-low), load (priority), advance, term.
module fib_term_gen
  import checker_pkg::*;
#(
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [DATA_W-1:0] SEED0  = DATA_W'(1),
  parameter logic [DATA_W-1:0] SEED1  = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] term
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q <= SEED0;
      b_q <= SEED1;
    end else if (load) begin
      a_q <= SEED0;
      b_q <= SEED1;
    end else if (advance) begin
      a_q <= b_q;
      b_q <= a_q + b_q;
    end
  end

  assign term = a_q;

endmodule

// File: rtl/fib_store_checker.sv
// Snoops data-memory stores and checks a windowed Fibonacci sequence in order.
// Ports: clk, rst (sync, active-low), start, st_valid/st_addr/st_data in;
// busy, done, pass, fail, timeout, match_count, first_err_idx,
// first_err_data, cycle_count out. Watchdog enabled by CHECKER_TIMEOUT_EN.
module fib_store_checker
  import checker_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                NUM_TERMS   = 9,
  parameter int                BASE_ADDR   = 2,
  parameter logic [DATA_W-1:0] SEED0       = DATA_W'(1),
  parameter logic [DATA_W-1:0] SEED1       = DATA_W'(1),
  parameter int                TIMEOUT_CYC = 120,
  localparam int               CNT_W       = $clog2(NUM_TERMS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic [31:0]       cycle_count
);

`ifdef CHECKER_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  localparam logic [31:0] WIN_LO = BASE_ADDR;
  localparam logic [31:0] WIN_HI = BASE_ADDR + NUM_TERMS;
  localparam logic [31:0] WD_LIM = TIMEOUT_CYC;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] term;
  logic [31:0]       addr32;
  logic [31:0]       exp_addr;
  logic [31:0]       cyc_inc;
  logic              run;
  logic              in_win;
  logic              hit;
  logic              bad;
  logic              last;
  logic              wd_fire;

  fib_term_gen #(
    .DATA_W (DATA_W),
    .SEED0  (SEED0),
    .SEED1  (SEED1)
  ) u_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .advance (hit),
    .term    (term)
  );

  assign run      = (state_q == RUN);
  assign addr32   = 32'(st_addr);
  assign exp_addr = WIN_LO + 32'(idx_q);
  assign in_win   = st_valid && addr32 >= WIN_LO
                 && addr32 < WIN_HI;
  assign hit      = run && in_win
                 && addr32 == exp_addr
                 && st_data == term;
  assign bad      = run && in_win && !hit;
  assign last     = (idx_q == CNT_W'(NUM_TERMS-1));
  assign cyc_inc  = (&cycle_count) ? cycle_count
                                   : cycle_count + 32'd1;
  // An in-window store owns its edge; the watchdog waits for a quiet one.
  assign wd_fire  = WD_EN && run && !in_win
                 && cyc_inc >= WD_LIM;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (run) begin
      if (hit && last) state_d = PASS;
      else if (bad)    state_d = FAIL;
      else if (wd_fire) state_d = FAIL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || start) begin
      idx_q          <= '0;
      match_count    <= '0;
      cycle_count    <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
    end else if (run) begin
      cycle_count <= cyc_inc;
      if (hit) begin
        idx_q       <= idx_q + 1'b1;
        match_count <= match_count + 1'b1;
      end else if (bad) begin
        first_err_idx  <= idx_q;
        first_err_data <= st_data;
      end else if (wd_fire) begin
        timeout        <= 1'b1;
        first_err_idx  <= idx_q;
        first_err_data <= '0;
      end
    end
  end

  assign busy = run;
  assign pass = (state_q == PASS);
  assign fail = (state_q == FAIL);
  assign done = pass || fail;

endmodule

// File: tb/tb_fib_store_checker.sv
// Randomised self-checking bench for fib_store_checker.
// Compares every cycle against a transaction-level model.
module tb_fib_store_checker;

  localparam int N    = 9;
  localparam int BASE = 2;
  localparam int TMO  = 120;
`ifdef CHECKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        st_valid;
  logic [7:0]  st_addr;
  logic [63:0] st_data;
  logic        busy, done, pass, fail, timeout;
  logic [3:0]  match_count, first_err_idx;
  logic [63:0] first_err_data;
  logic [31:0] cycle_count;

  fib_store_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .match_count    (match_count),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          ticks = 0;
  logic [63:0] fib [N];

  // model: 0 idle, 1 run, 2 pass, 3 fail
  int          m_state;
  int          m_idx;
  int          m_match;
  longint      m_cyc;
  int          m_err_idx;
  logic [63:0] m_err_data;
  bit          m_tmo;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(bit r, bit s, bit v, int a,
                       logic [63:0] d);
    bit inw;
    if (!r) begin
      m_state = 0; m_idx = 0; m_match = 0; m_cyc = 0;
      m_err_idx = 0; m_err_data = 0; m_tmo = 0;
    end else if (s) begin
      m_state = 1; m_idx = 0; m_match = 0; m_cyc = 0;
      m_err_idx = 0; m_err_data = 0; m_tmo = 0;
    end else if (m_state == 1) begin
      if (m_cyc < 64'hffff_ffff) m_cyc++;
      inw = v && a >= BASE && a < BASE + N;
      if (inw) begin
        if (a == BASE + m_idx && d == fib[m_idx]) begin
          m_idx++;
          m_match++;
          if (m_idx == N) m_state = 2;
        end else begin
          m_state = 3;
          m_err_idx = m_idx;
          m_err_data = d;
        end
      end else if (TMO_EN && m_cyc >= TMO) begin
        m_state = 3;
        m_tmo = 1;
        m_err_idx = m_idx;
        m_err_data = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("busy", busy, m_state == 1);
    check("done", done, m_state >= 2);
    check("pass", pass, m_state == 2);
    check("fail", fail, m_state == 3);
    check("timeout", timeout, m_tmo);
    check("match_count", match_count, m_match);
    check("err_idx", first_err_idx, m_err_idx);
    check("err_data", first_err_data, m_err_data);
    check("cycle_count", cycle_count, m_cyc);
  endtask

  task automatic tick(bit r, bit s, bit v, int a,
                      logic [63:0] d);
    rst = r; start = s; st_valid = v;
    st_addr = 8'(a); st_data = d;
    @(posedge clk);
    model(r, s, v, a, d);
    ticks++;
    #1;
    compare_all();
  endtask

  task automatic idle(int n);
    repeat (n) tick(1, 0, 0, 0, 64'd0);
  endtask

  task automatic store(int i);
    tick(1, 0, 1, BASE + i, fib[i]);
  endtask

  task automatic do_start();
    tick(1, 1, 0, 0, 64'd0);
  endtask

  task automatic noise();
    int pick [4] = '{0, 1, 11, 200};
    tick(1, 0, 1, pick[$urandom_range(0, 3)],
         {$urandom, $urandom});
  endtask

  task automatic run_seq(bit with_noise);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if (with_noise) noise();
        else idle(1);
      end
      store(i);
    end
  endtask

  initial begin
    int t0;
    fib[0] = 64'd1;
    fib[1] = 64'd1;
    for (int i = 2; i < N; i++) fib[i] = fib[i-1] + fib[i-2];

    // reset
    tick(0, 0, 0, 0, 64'd0);
    tick(0, 1, 1, BASE, 64'd1);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", cycle_count, 32'd0);
    idle(2);

    // full correct run with gaps
    do_start();
    check("start_busy", busy, 1'b1);
    t0 = ticks;
    run_seq(0);
    check("s1_pass", pass, 1'b1);
    check("s1_match", match_count, 4'd9);
    check("s1_fail", fail, 1'b0);
    check("s1_cycles", cycle_count, 32'(ticks - t0));
    idle(3);

    // wrong data at term 4, later stores ignored
    do_start();
    for (int i = 0; i < 4; i++) store(i);
    tick(1, 0, 1, BASE + 4, 64'd6);
    for (int i = 4; i < N; i++) store(i);
    check("s2_fail", fail, 1'b1);
    check("s2_idx", first_err_idx, 4'd4);
    check("s2_data", first_err_data, 64'd6);

    // out-of-order address
    do_start();
    store(0);
    tick(1, 0, 1, BASE + 2, 64'd2);
    check("s3_fail", fail, 1'b1);
    check("s3_idx", first_err_idx, 4'd1);
    check("s3_data", first_err_data, 64'd2);

    // out-of-window noise
    do_start();
    run_seq(1);
    check("s4_pass", pass, 1'b1);
    check("s4_match", match_count, 4'd9);

    // watchdog
    do_start();
    for (int i = 0; i < 5; i++) store(i);
    for (int k = 0; k < 200 && m_state == 1; k++) idle(1);
    if (TMO_EN) begin
      check("s5_fail", fail, 1'b1);
      check("s5_tmo", timeout, 1'b1);
      check("s5_cycles", cycle_count, 32'd120);
      check("s5_idx", first_err_idx, 4'd5);
      check("s5_data", first_err_data, 64'd0);
    end else begin
      check("s5_busy", busy, 1'b1);
      check("s5_tmo", timeout, 1'b0);
    end

    // reset mid-run
    do_start();
    for (int i = 0; i < 4; i++) store(i);
    tick(0, 0, 0, 0, 64'd0);
    check("s6_match", match_count, 4'd0);
    check("s6_busy", busy, 1'b0);
    do_start();
    run_seq(0);
    check("s6_pass", pass, 1'b1);

    // restart mid-run; store with start is dropped
    do_start();
    for (int i = 0; i < 3; i++) store(i);
    tick(1, 1, 1, BASE, 64'd1);
    check("s7_match", match_count, 4'd0);
    check("s7_cycles", cycle_count, 32'd0);
    run_seq(0);
    check("s7_pass", pass, 1'b1);

    // random mix of good, noisy and bad stores
    for (int r = 0; r < 20; r++) begin
      do_start();
      for (int k = 0; k < 40 && m_state == 1; k++) begin
        int sel = $urandom_range(0, 19);
        if (sel < 12) store(m_idx);
        else if (sel < 16) noise();
        else if (sel < 18) idle(1);
        else tick(1, 0, 1, BASE + $urandom_range(0, N - 1),
                  64'($urandom_range(0, 40)));
      end
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
